// File: rtl/bsg_dmc_ui_mux_pkg.sv
// Shared types for the DMC UI multi-port mux: UI command encoding and command classification.
package bsg_dmc_ui_mux_pkg;

    typedef enum logic [2:0] {
        WR = 3'b000,
        RD = 3'b001,
        RP = 3'b010,
        WP = 3'b011
    } app_cmd_e;

    typedef enum logic {
        ARB   = 1'b0,
        WDATA = 1'b1
    } ui_mux_state_e;

    localparam int unsigned perf_cnt_width_lp = 32;

    // Anything that is not a write is tracked as a read returning data.
    function automatic logic is_write_cmd(input app_cmd_e cmd);
        return (cmd == WR) || (cmd == WP);
    endfunction

endpackage

// File: rtl/bsg_dmc_ui_rd_route.sv
// Read-return router: FIFO of granted read port IDs, head decode onto per-port valid/end,
// and a sticky flag for read data arriving with nothing outstanding.
module bsg_dmc_ui_rd_route
    import bsg_dmc_ui_mux_pkg::*;
#(
    parameter int unsigned num_ports_p = 2,
    parameter int unsigned depth_p     = 4,
    parameter int unsigned id_width_p  = $clog2(num_ports_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic [id_width_p-1:0]  push_id_i,
    output logic                   full_o,
    input  logic                   rd_valid_i,
    input  logic                   rd_end_i,
    output logic [num_ports_p-1:0] rd_valid_o,
    output logic [num_ports_p-1:0] rd_end_o,
    output logic                   underflow_o
);

    localparam int unsigned ptr_width_lp = $clog2(depth_p);
    localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

    logic [id_width_p-1:0]   mem_q [depth_p];
    logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    underflow_q, underflow_d;
    logic                    empty, full, push, pop;
    logic [id_width_p-1:0]   head;

    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_width_lp'(depth_p));
    assign pop   = rd_valid_i & rd_end_i & ~empty;
    // A push into a full FIFO is fine when the head pops in the same cycle.
    assign push  = push_i & (~full | pop);
    assign head  = mem_q[rptr_q];

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
        underflow_d = underflow_q | (rd_valid_i & empty);
        if (push) wptr_d = wptr_q + ptr_width_lp'(1);
        if (pop)  rptr_d = rptr_q + ptr_width_lp'(1);
    end

    always_comb begin
        rd_valid_o = '0;
        rd_end_o   = '0;
        if (~empty && ~reset_i) begin
            rd_valid_o[head] = rd_valid_i;
            rd_end_o[head]   = rd_valid_i & rd_end_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= push_id_i;
    end

    assign full_o      = full;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/bsg_dmc_ui_mux.sv
// Round-robin multi-port front end onto the bsg_dmc app_* interface.
// Optional per-port command/stall counters when BSG_DMC_UI_MUX_PERF_EN is defined.
module bsg_dmc_ui_mux
    import bsg_dmc_ui_mux_pkg::*;
#(
    parameter int unsigned num_ports_p     = 2,
    parameter int unsigned ui_addr_width_p = 28,
    parameter int unsigned ui_data_width_p = 64,
    parameter int unsigned rd_fifo_depth_p = 4
) (
    input  logic                                          ui_clk_i,
    input  logic                                          ui_clk_sync_rst_i,
    input  logic [num_ports_p*ui_addr_width_p-1:0]        p_app_addr_i,
    input  logic [num_ports_p*$bits(app_cmd_e)-1:0]       p_app_cmd_i,
    input  logic [num_ports_p-1:0]                        p_app_en_i,
    output logic [num_ports_p-1:0]                        p_app_rdy_o,
    input  logic [num_ports_p-1:0]                        p_app_wdf_wren_i,
    input  logic [num_ports_p-1:0]                        p_app_wdf_end_i,
    input  logic [num_ports_p*ui_data_width_p-1:0]        p_app_wdf_data_i,
    input  logic [num_ports_p*(ui_data_width_p>>3)-1:0]   p_app_wdf_mask_i,
    output logic [num_ports_p-1:0]                        p_app_wdf_rdy_o,
    output logic [num_ports_p-1:0]                        p_app_rd_data_valid_o,
    output logic [num_ports_p-1:0]                        p_app_rd_data_end_o,
    output logic [ui_data_width_p-1:0]                    p_app_rd_data_o,
    output logic [ui_addr_width_p-1:0]                    app_addr_o,
    output app_cmd_e                                      app_cmd_o,
    output logic                                          app_en_o,
    input  logic                                          app_rdy_i,
    output logic                                          app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]                    app_wdf_data_o,
    output logic [(ui_data_width_p>>3)-1:0]               app_wdf_mask_o,
    output logic                                          app_wdf_end_o,
    input  logic                                          app_wdf_rdy_i,
    input  logic                                          app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]                    app_rd_data_i,
    input  logic                                          app_rd_data_end_i,
`ifdef BSG_DMC_UI_MUX_PERF_EN
    output logic [num_ports_p*perf_cnt_width_lp-1:0]      perf_cmd_cnt_o,
    output logic [num_ports_p*perf_cnt_width_lp-1:0]      perf_stall_cnt_o,
`endif
    output logic                                          rd_underflow_o
);

    localparam int unsigned id_width_lp   = $clog2(num_ports_p);
    localparam int unsigned cmd_width_lp  = $bits(app_cmd_e);
    localparam int unsigned mask_width_lp = ui_data_width_p >> 3;

    ui_mux_state_e          state_q, state_d;
    logic [id_width_lp-1:0] rr_q, rr_d, owner_q, owner_d;
    logic [id_width_lp-1:0] winner, idx;
    app_cmd_e               cmd [num_ports_p];
    logic [num_ports_p-1:0] eligible;
    logic                   has_winner, in_arb, in_wdata, accept, burst_done, rd_full, rd_push;

    // Reads are held off while every return slot is already claimed.
    always_comb begin
        for (int i = 0; i < num_ports_p; i++) begin
            cmd[i]      = app_cmd_e'(p_app_cmd_i[i*cmd_width_lp +: cmd_width_lp]);
            eligible[i] = p_app_en_i[i] & (is_write_cmd(cmd[i]) | ~rd_full);
        end
    end

    // Scan downward so the nearest eligible port at or after rr_q wins.
    always_comb begin
        has_winner = 1'b0;
        winner     = rr_q;
        idx        = rr_q;
        for (int k = num_ports_p - 1; k >= 0; k--) begin
            idx = id_width_lp'((int'(rr_q) + k) % int'(num_ports_p));
            if (eligible[idx]) begin
                has_winner = 1'b1;
                winner     = idx;
            end
        end
    end

    always_comb begin
        in_arb         = (state_q == ARB) & ~ui_clk_sync_rst_i;
        in_wdata       = (state_q == WDATA) & ~ui_clk_sync_rst_i;
        app_en_o       = in_arb & has_winner;
        app_addr_o     = p_app_addr_i[winner*ui_addr_width_p +: ui_addr_width_p];
        app_cmd_o      = cmd[winner];
        p_app_rdy_o    = '0;
        if (app_en_o) p_app_rdy_o[winner] = app_rdy_i;
        accept         = app_en_o & app_rdy_i;
        rd_push        = accept & ~is_write_cmd(cmd[winner]);

        app_wdf_wren_o  = in_wdata & p_app_wdf_wren_i[owner_q];
        app_wdf_end_o   = in_wdata & p_app_wdf_end_i[owner_q];
        app_wdf_data_o  = p_app_wdf_data_i[owner_q*ui_data_width_p +: ui_data_width_p];
        app_wdf_mask_o  = p_app_wdf_mask_i[owner_q*mask_width_lp +: mask_width_lp];
        p_app_wdf_rdy_o = '0;
        if (in_wdata) p_app_wdf_rdy_o[owner_q] = app_wdf_rdy_i;
        burst_done      = app_wdf_wren_o & app_wdf_rdy_i & app_wdf_end_o;

        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        if (accept) begin
            rr_d = (winner == id_width_lp'(num_ports_p - 1)) ? '0 : winner + id_width_lp'(1);
            if (is_write_cmd(cmd[winner])) begin
                owner_d = winner;
                state_d = WDATA;
            end
        end
        if (burst_done) state_d = ARB;
    end

    always_ff @(posedge ui_clk_i) begin
        if (ui_clk_sync_rst_i) begin
            state_q <= ARB;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    bsg_dmc_ui_rd_route #(
        .num_ports_p (num_ports_p),
        .depth_p     (rd_fifo_depth_p),
        .id_width_p  (id_width_lp)
    ) rd_route (
        .clk_i       (ui_clk_i),
        .reset_i     (ui_clk_sync_rst_i),
        .push_i      (rd_push),
        .push_id_i   (winner),
        .full_o      (rd_full),
        .rd_valid_i  (app_rd_data_valid_i),
        .rd_end_i    (app_rd_data_end_i),
        .rd_valid_o  (p_app_rd_data_valid_o),
        .rd_end_o    (p_app_rd_data_end_o),
        .underflow_o (rd_underflow_o)
    );

    assign p_app_rd_data_o = app_rd_data_i;

`ifdef BSG_DMC_UI_MUX_PERF_EN
    logic [num_ports_p-1:0][perf_cnt_width_lp-1:0] cmd_cnt_q, cmd_cnt_d, stall_cnt_q, stall_cnt_d;

    // Saturating per-port accepted-command and stalled-request cycle counts.
    always_comb begin
        cmd_cnt_d   = cmd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < num_ports_p; i++) begin
            if (p_app_en_i[i] & p_app_rdy_o[i] & ~(&cmd_cnt_q[i]))
                cmd_cnt_d[i] = cmd_cnt_q[i] + perf_cnt_width_lp'(1);
            if (p_app_en_i[i] & ~p_app_rdy_o[i] & ~(&stall_cnt_q[i]))
                stall_cnt_d[i] = stall_cnt_q[i] + perf_cnt_width_lp'(1);
        end
    end

    always_ff @(posedge ui_clk_i) begin
        if (ui_clk_sync_rst_i) begin
            cmd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            cmd_cnt_q   <= cmd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_cmd_cnt_o   = cmd_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`else
    // No performance counters in this build.
`endif

endmodule
